// File: rtl/uart6551_pkg.sv
// Shared types and constants for the 6551 ACIA serial blocks.
package uart6551_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [1:0] WL_8 = 2'd0;
  localparam logic [1:0] WL_7 = 2'd1;
  localparam logic [1:0] WL_6 = 2'd2;
  localparam logic [1:0] WL_5 = 2'd3;

  localparam logic [3:0] TICK_MID = 4'd7;
  localparam logic [3:0] TICK_END = 4'd15;

  // Prescaler divisor (CLK_6551_EN pulses per 16x tick) for each baud code.
  function automatic logic [12:0] baud_div(input logic [3:0] sel);
    logic [12:0] d;
    case (sel)
      4'd0:    d = 13'd2;
      4'd1:    d = 13'd4608;
      4'd2:    d = 13'd3072;
      4'd3:    d = 13'd2094;
      4'd4:    d = 13'd1712;
      4'd5:    d = 13'd1536;
      4'd6:    d = 13'd768;
      4'd7:    d = 13'd384;
      4'd8:    d = 13'd192;
      4'd9:    d = 13'd128;
      4'd10:   d = 13'd96;
      4'd11:   d = 13'd64;
      4'd12:   d = 13'd48;
      4'd13:   d = 13'd32;
      4'd14:   d = 13'd24;
      default: d = 13'd12;
    endcase
    return d;
  endfunction

  // Index of the final data bit for a word-length code (8 bits -> 7 ... 5 bits -> 4).
  function automatic logic [2:0] last_bit(input logic [1:0] wl);
    return 3'd7 - {1'b0, wl};
  endfunction

endpackage

// File: rtl/uart6551_baudgen.sv
// 16x oversampling tick prescaler; counts CLK_6551_EN pulses, held at zero on request.
module uart6551_baudgen
  import uart6551_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [12:0] div,
  input  logic        hold,
  output logic        tick16
);

  logic [12:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick16 <= 1'b0;
    end else if (hold) begin
      cnt    <= '0;
      tick16 <= 1'b0;
    end else begin
      tick16 <= 1'b0;
      if (clk_en) begin
        if (cnt == div - 13'd1) begin
          cnt    <= '0;
          tick16 <= 1'b1;
        end else begin
          cnt <= cnt + 13'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart6551_rx.sv
// 6551 ACIA receiver: RXD synchroniser, frame deserialiser and receive holding register.
// state  | meaning
// IDLE   | waiting for a high->low edge on synced RXD, prescaler held
// START  | qualifying the start bit at its midpoint
// DATA   | shifting in WORD_LEN data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then loading the holding register
module uart6551_rx
  import uart6551_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_6551_EN,
  input  logic [3:0] BAUD_SEL,
  input  logic [1:0] WORD_LEN,
  input  logic       PARITY_EN,
  input  logic       PARITY_ODD,
  input  logic       RXD,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_FULL,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERRUN
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_prev;
  logic                   fall;

  rx_state_t   state;
  logic [3:0]  t;
  logic [2:0]  n;
  logic [7:0]  shreg;
  logic        par_err;
  logic [12:0] div_q;
  logic [1:0]  wl_q;
  logic        pen_q;
  logic        podd_q;
  logic        tick16;
  logic        load;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q   <= '1;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], RXD};
      rxd_prev <= rxd_s;
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_prev & ~rxd_s;
  assign load  = (state == STOP) && tick16 && (t == TICK_END);

  uart6551_baudgen u_baudgen (
    .clk    (CLK),
    .rst    (RESET),
    .clk_en (CLK_6551_EN),
    .div    (div_q),
    .hold   (state == IDLE),
    .tick16 (tick16)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      t           <= '0;
      n           <= '0;
      shreg       <= '0;
      par_err     <= 1'b0;
      div_q       <= '0;
      wl_q        <= WL_8;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      RX_DATA     <= '0;
      RX_FULL     <= 1'b0;
      PARITY_ERR  <= 1'b0;
      FRAMING_ERR <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            t      <= '0;
            div_q  <= baud_div(BAUD_SEL);
            wl_q   <= WORD_LEN;
            pen_q  <= PARITY_EN;
            podd_q <= PARITY_ODD;
          end
        end
        START: begin
          if (tick16) begin
            if (t == TICK_MID) begin
              if (rxd_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                t       <= '0;
                n       <= '0;
                shreg   <= '0;
                par_err <= 1'b0;
              end
            end else begin
              t <= t + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick16) begin
            if (t == TICK_END) begin
              shreg <= {rxd_s, shreg[7:1]};
              t     <= '0;
              if (n == last_bit(wl_q)) state <= pen_q ? PARITY : STOP;
              else                     n     <= n + 3'd1;
            end else begin
              t <= t + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick16) begin
            if (t == TICK_END) begin
              par_err <= ((^shreg) ^ rxd_s) != podd_q;
              t       <= '0;
              state   <= STOP;
            end else begin
              t <= t + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick16) begin
            if (t == TICK_END) begin
              t     <= '0;
              state <= IDLE;
            end else begin
              t <= t + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A load in the same cycle as an ACK replaces the held character instead of clearing it.
      if (load) begin
        if (!RX_FULL || RX_ACK) begin
          RX_DATA     <= shreg >> wl_q;
          PARITY_ERR  <= par_err;
          FRAMING_ERR <= ~rxd_s;
          RX_FULL     <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (RX_ACK) begin
        RX_FULL     <= 1'b0;
        PARITY_ERR  <= 1'b0;
        FRAMING_ERR <= 1'b0;
        OVERRUN     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart6551_rx.md
Name: uart6551_rx

Overview:
- Serial receiver for the 6551 ACIA emulation.
- Consumes the 3.6864 MHz CLK_6551_EN clock-enable. Derives a 16x oversampling tick from the 6551 baud-select code. Deframes asynchronous serial data from RXD.
- Presents one received character in a holding register with full/error flags, read by the ACIA register interface via RX_ACK.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RXD input synchroniser (minimum 2).

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- CLK_6551_EN  input  1  single-CLK pulse at 3.6864 MHz average rate
- BAUD_SEL  input  4  6551 control register bits 3:0
- WORD_LEN  input  2  6551 word length: 0=8, 1=7, 2=6, 3=5 bits
- PARITY_EN  input  1  1 = parity bit expected after data
- PARITY_ODD  input  1  1 = odd parity, 0 = even
- RXD  input  1  asynchronous serial line, idle high
- RX_ACK  input  1  one-CLK pulse: CPU has read the data register
- RX_DATA  output  8  received character, unused upper bits zero
- RX_FULL  output  1  holding register contains an unread character
- PARITY_ERR  output  1  parity mismatch on the held character
- FRAMING_ERR  output  1  stop bit sampled low on the held character
- OVERRUN  output  1  a character arrived while RX_FULL was set

Behaviour:
- Reset (asynchronous, RESET=1): all outputs 0, state IDLE, prescaler and tick counters 0, synchroniser all 1s.
- Baud divisor D from BAUD_SEL:
  - 0→2 (115200 extension), 1→4608, 2→3072, 3→2094, 4→1712, 5→1536, 6→768, 7→384.
  - 8→192, 9→128, 10→96, 11→64, 12→48, 13→32, 14→24, 15→12.
  - Example: BAUD_SEL=14 gives 9600 baud, BAUD_SEL=15 gives 19200 baud.
- tick16:
  - One-CLK pulse on every D-th CLK_6551_EN pulse.
  - 13-bit prescaler counts 0..D-1 on CLK_6551_EN and asserts tick16 at wrap.
  - Prescaler is held at 0 while IDLE, so phase aligns to the start edge.
- Config capture: D, WORD_LEN, PARITY_EN and PARITY_ODD are latched on entry to START. Changes mid-frame take effect on the next frame.
- State machine (tick counter t, 4 bits; bit counter n, 3 bits):
  - IDLE: synced RXD high→low edge → START, t=0.
  - START: on tick16 with t==7, sample RXD. If high (glitch) → IDLE. If low → DATA, t=0, n=0. Otherwise t++ on tick16.
  - DATA: on tick16 with t==15, shift the sampled bit in LSB-first, t=0. After WORD_LEN bits → PARITY if PARITY_EN, else STOP.
  - PARITY: sample at t==15. Error = XOR(data bits, parity bit) != PARITY_ODD. → STOP.
  - STOP: sample at t==15. Low → framing error. Load the holding register (see below) → IDLE.
- A new start requires a fresh high→low edge. A break (line held low) therefore yields exactly one framed character with FRAMING_ERR and no repeats.
- Load into the holding register (one CLK, at the stop sample):
  - RX_FULL=0: RX_DATA←data right-aligned, PARITY_ERR/FRAMING_ERR←frame flags, RX_FULL←1.
  - RX_FULL=1 and RX_ACK=0 that cycle: old RX_DATA and its flags are retained, OVERRUN←1, new character discarded.
  - RX_FULL=1 and RX_ACK=1 same cycle: load wins. New data and flags are stored, RX_FULL stays 1, OVERRUN unchanged by this event.
- RX_ACK without a simultaneous load: clears RX_FULL, PARITY_ERR, FRAMING_ERR and OVERRUN next CLK. RX_DATA holds its value. RX_ACK with RX_FULL=0 is harmless.
- Latency: RX_FULL rises 1 CLK after the tick16 that samples the stop bit.
- Reset mid-frame aborts the frame. No partial character is ever loaded.

Decomposition:
- Package uart6551_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - baud divisor lookup function (BAUD_SEL→13-bit D)
  - WORD_LEN encoding constants
  - tick midpoint/end constants 7 and 15
- Sub-module uart6551_baudgen: prescaler producing tick16 from CLK_6551_EN, D and a hold input. Reusable by the future transmitter.

Test Plan:
- Bench conditions: CLK_6551_EN every 2nd CLK; BAUD_SEL=15 (D=12); 8N1. Bit period = 16×12×2 = 384 CLK.
- 8N1 basic: send 0xA5 → RX_FULL=1, RX_DATA=0xA5, PARITY_ERR=0, FRAMING_ERR=0. RX_ACK → RX_FULL=0, RX_DATA still 0xA5.
- 7-bit odd parity (WORD_LEN=1, PARITY_EN=1, PARITY_ODD=1):
  - 0x41 with parity bit 1 → RX_DATA=0x41, PARITY_ERR=0.
  - Resend with parity bit 0 → PARITY_ERR=1.
- Glitch and break:
  - 100-CLK low pulse on RXD → no RX_FULL; state returns to IDLE.
  - Line held low for 20 bit periods → exactly one character 0x00 with FRAMING_ERR=1.
- Overrun: send 0x11 and 0x22 with no ACK → RX_DATA=0x11, OVERRUN=1. RX_ACK → all flags 0.
- ACK/load collision: assert RX_ACK in the exact cycle 0x33 loads while 0x11 is held → RX_DATA=0x33, RX_FULL=1, OVERRUN=0.
- 5-bit data and reset:
  - WORD_LEN=3, send 0x1F → RX_DATA=0x1F with bits 7:5 = 0.
  - Assert RESET mid-DATA → all outputs 0 immediately; the next full frame is received correctly.
